// File: rtl/main_fifo_reader_pkg.sv
// -----------------------------------------------------------------------------
// main_fifo_reader_pkg
// Shared definitions for the main FIFO drain controller: FSM state encoding,
// default widths and a small state-classification helper.
// -----------------------------------------------------------------------------
package main_fifo_reader_pkg;

  localparam int DATA_WIDTH_DEF   = 6;
  localparam int UMBRAL_WIDTH_DEF = 4;
  localparam int CNT_WIDTH_DEF    = 8;
  localparam int STATE_WIDTH      = 3;

  typedef enum logic [STATE_WIDTH-1:0] {
    ST_RESET  = 3'd0,
    ST_INIT   = 3'd1,
    ST_IDLE   = 3'd2,
    ST_ACTIVE = 3'd3,
    ST_ERROR  = 3'd4
  } state_e;

  // True in the two operational states where traffic may flow.
  function automatic logic is_run_state(input state_e s);
    return (s == ST_IDLE) || (s == ST_ACTIVE);
  endfunction

endpackage

// File: rtl/main_fifo_reader_if.sv
// -----------------------------------------------------------------------------
// main_fifo_reader_if
// Bundles the main FIFO read port and the two VC FIFO write ports.
//   main_rd_enable            : read strobe to main FIFO
//   main_empty/main_error     : main FIFO status
//   main_data                 : main FIFO data_out (valid the cycle after a read)
//   vc0/vc1_almost_full       : downstream backpressure
//   vc0/vc1_wr_enable,vc_data : write port shared by both VC FIFOs
// master = the reader, slave = the FIFO side.
// -----------------------------------------------------------------------------
interface main_fifo_reader_if
  import main_fifo_reader_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) ();

  logic                  main_rd_enable;
  logic                  main_empty;
  logic                  main_error;
  logic [DATA_WIDTH-1:0] main_data;
  logic                  vc0_almost_full;
  logic                  vc1_almost_full;
  logic                  vc0_wr_enable;
  logic                  vc1_wr_enable;
  logic [DATA_WIDTH-1:0] vc_data;

  modport master (
    output main_rd_enable, vc0_wr_enable, vc1_wr_enable, vc_data,
    input  main_empty, main_error, main_data, vc0_almost_full, vc1_almost_full
  );

  modport slave (
    input  main_rd_enable, vc0_wr_enable, vc1_wr_enable, vc_data,
    output main_empty, main_error, main_data, vc0_almost_full, vc1_almost_full
  );

endinterface

// File: rtl/main_fifo_reader_vc_route_stage.sv
// -----------------------------------------------------------------------------
// main_fifo_reader_vc_route_stage
// Capture stage behind the main FIFO read port. Remembers that a read was
// issued (pending), captures the word the cycle after, demuxes it by MSB to
// VC0/VC1 with registered strobes, and counts words per channel.
// Ports:
//   clk, reset      : clock, synchronous active-high reset
//   clear_i         : drop pending word, zero strobes and counters
//   drop_i          : discard the pending word without touching counters
//   rd_en_i         : read strobe issued this cycle
//   data_i          : main FIFO data_out
//   pending_o       : a read is in flight
//   vc0/vc1_wr_o    : registered write strobes
//   vc_data_o       : registered data to both VC FIFOs
//   vc0/vc1_count_o : words routed per VC (wrap)
// -----------------------------------------------------------------------------
module main_fifo_reader_vc_route_stage
  import main_fifo_reader_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int CNT_WIDTH  = CNT_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clear_i,
  input  logic                  drop_i,
  input  logic                  rd_en_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  output logic                  pending_o,
  output logic                  vc0_wr_o,
  output logic                  vc1_wr_o,
  output logic [DATA_WIDTH-1:0] vc_data_o,
  output logic [CNT_WIDTH-1:0]  vc0_count_o,
  output logic [CNT_WIDTH-1:0]  vc1_count_o
);

  logic                  pending_q, pending_d;
  logic                  vc0_wr_q, vc0_wr_d;
  logic                  vc1_wr_q, vc1_wr_d;
  logic [DATA_WIDTH-1:0] vc_data_q, vc_data_d;
  logic [CNT_WIDTH-1:0]  vc0_cnt_q, vc0_cnt_d;
  logic [CNT_WIDTH-1:0]  vc1_cnt_q, vc1_cnt_d;

  // Next-value logic for the capture/demux registers.
  always_comb begin
    pending_d = rd_en_i & ~clear_i;
    vc0_wr_d  = 1'b0;
    vc1_wr_d  = 1'b0;
    vc_data_d = vc_data_q;
    vc0_cnt_d = vc0_cnt_q;
    vc1_cnt_d = vc1_cnt_q;
    if (clear_i) begin
      vc0_cnt_d = '0;
      vc1_cnt_d = '0;
    end else if (pending_q && !drop_i) begin
      vc_data_d = data_i;
      // MSB selects the destination virtual channel.
      if (data_i[DATA_WIDTH-1]) begin
        vc1_wr_d  = 1'b1;
        vc1_cnt_d = vc1_cnt_q + CNT_WIDTH'(1);
      end else begin
        vc0_wr_d  = 1'b1;
        vc0_cnt_d = vc0_cnt_q + CNT_WIDTH'(1);
      end
    end else begin
      vc_data_d = vc_data_q;
    end
  end

  // Capture/demux registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      pending_q <= 1'b0;
      vc0_wr_q  <= 1'b0;
      vc1_wr_q  <= 1'b0;
      vc_data_q <= '0;
      vc0_cnt_q <= '0;
      vc1_cnt_q <= '0;
    end else begin
      pending_q <= pending_d;
      vc0_wr_q  <= vc0_wr_d;
      vc1_wr_q  <= vc1_wr_d;
      vc_data_q <= vc_data_d;
      vc0_cnt_q <= vc0_cnt_d;
      vc1_cnt_q <= vc1_cnt_d;
    end
  end

  assign pending_o   = pending_q;
  assign vc0_wr_o    = vc0_wr_q;
  assign vc1_wr_o    = vc1_wr_q;
  assign vc_data_o   = vc_data_q;
  assign vc0_count_o = vc0_cnt_q;
  assign vc1_count_o = vc1_cnt_q;

endmodule

// File: rtl/main_fifo_reader.sv
// -----------------------------------------------------------------------------
// main_fifo_reader
// Drain controller on the read side of the main FIFO (PCIe TX path). Reads
// while the main FIFO has data and both VC FIFOs have room, then routes each
// word by MSB to VC0/VC1 two cycles after the read strobe.
// Ports:
//   clk, reset                  : clock, synchronous active-high reset
//   init                        : active-low init; low holds INIT
//   umbral_main_in/umbral_vc_in : thresholds latched while in INIT
//   bus (master)                : main FIFO read port + VC FIFO write ports
//   umbral_main/umbral_vc       : latched thresholds
//   vc0_count/vc1_count         : words routed per VC
//   state                       : current FSM state
//   idle                        : running, nothing in flight, main FIFO empty
// -----------------------------------------------------------------------------
module main_fifo_reader
  import main_fifo_reader_pkg::*;
#(
  parameter int DATA_WIDTH   = DATA_WIDTH_DEF,
  parameter int UMBRAL_WIDTH = UMBRAL_WIDTH_DEF,
  parameter int CNT_WIDTH    = CNT_WIDTH_DEF
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    init,
  input  logic [UMBRAL_WIDTH-1:0] umbral_main_in,
  input  logic [UMBRAL_WIDTH-1:0] umbral_vc_in,
  main_fifo_reader_if.master      bus,
  output logic [UMBRAL_WIDTH-1:0] umbral_main,
  output logic [UMBRAL_WIDTH-1:0] umbral_vc,
  output logic [CNT_WIDTH-1:0]    vc0_count,
  output logic [CNT_WIDTH-1:0]    vc1_count,
  output logic [STATE_WIDTH-1:0]  state,
  output logic                    idle
);

  state_e                  state_q, state_d;
  logic [UMBRAL_WIDTH-1:0] umbral_main_q, umbral_main_d;
  logic [UMBRAL_WIDTH-1:0] umbral_vc_q, umbral_vc_d;
  logic                    rd_en_s;
  logic                    clear_s;
  logic                    drop_s;
  logic                    pending_s;
  logic                    vc0_wr_s;
  logic                    vc1_wr_s;

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_RESET;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic; main_error outranks init and is ignored in RESET/INIT.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RESET: state_d = ST_INIT;
      ST_INIT: begin
        if (init) state_d = ST_IDLE;
        else      state_d = ST_INIT;
      end
      ST_IDLE: begin
        if (bus.main_error)      state_d = ST_ERROR;
        else if (!init)          state_d = ST_INIT;
        else if (!bus.main_empty) state_d = ST_ACTIVE;
        else                     state_d = ST_IDLE;
      end
      ST_ACTIVE: begin
        // Stay until the in-flight word has been captured.
        if (bus.main_error)                      state_d = ST_ERROR;
        else if (!init)                          state_d = ST_INIT;
        else if (bus.main_empty && !pending_s)   state_d = ST_IDLE;
        else                                     state_d = ST_ACTIVE;
      end
      ST_ERROR: state_d = ST_ERROR;
      default:  state_d = ST_RESET;
    endcase
  end

  // FSM outputs: read gating plus clear/drop controls for the route stage.
  always_comb begin
    rd_en_s = 1'b0;
    clear_s = 1'b0;
    drop_s  = 1'b0;
    case (state_q)
      ST_RESET, ST_INIT: clear_s = 1'b1;
      ST_IDLE: begin
        clear_s = ~init;
        drop_s  = bus.main_error;
      end
      ST_ACTIVE: begin
        // Combinational so the last word (count 1->0) is never over-read;
        // either almost_full blocks regardless of destination.
        rd_en_s = ~bus.main_empty & ~bus.vc0_almost_full &
                  ~bus.vc1_almost_full & init;
        clear_s = ~init;
        drop_s  = bus.main_error;
      end
      ST_ERROR: drop_s  = 1'b1;
      default:  clear_s = 1'b1;
    endcase
  end

  // Threshold latches follow their inputs only while in INIT.
  always_comb begin
    if (state_q == ST_INIT) begin
      umbral_main_d = umbral_main_in;
      umbral_vc_d   = umbral_vc_in;
    end else begin
      umbral_main_d = umbral_main_q;
      umbral_vc_d   = umbral_vc_q;
    end
  end

  // Threshold registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      umbral_main_q <= '0;
      umbral_vc_q   <= '0;
    end else begin
      umbral_main_q <= umbral_main_d;
      umbral_vc_q   <= umbral_vc_d;
    end
  end

  main_fifo_reader_vc_route_stage #(
    .DATA_WIDTH (DATA_WIDTH),
    .CNT_WIDTH  (CNT_WIDTH)
  ) u_route (
    .clk         (clk),
    .reset       (reset),
    .clear_i     (clear_s),
    .drop_i      (drop_s),
    .rd_en_i     (rd_en_s),
    .data_i      (bus.main_data),
    .pending_o   (pending_s),
    .vc0_wr_o    (vc0_wr_s),
    .vc1_wr_o    (vc1_wr_s),
    .vc_data_o   (bus.vc_data),
    .vc0_count_o (vc0_count),
    .vc1_count_o (vc1_count)
  );

  assign bus.main_rd_enable = rd_en_s;
  assign bus.vc0_wr_enable  = vc0_wr_s;
  assign bus.vc1_wr_enable  = vc1_wr_s;
  assign umbral_main        = umbral_main_q;
  assign umbral_vc          = umbral_vc_q;
  assign state              = state_q;
  assign idle               = is_run_state(state_q) & ~pending_s & ~vc0_wr_s &
                              ~vc1_wr_s & bus.main_empty;

endmodule
